wb_macro_mux: RTL and testbench

//  Parametrised Wishbone slave fan-out between the Caravel master and N user macros.

---
 rtl/wb_macro_mux.sv | 145 ++++++++++++++
 tb/tb_wb_macro_mux.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_macro_mux.sv
// wb_macro_mux: Wishbone fan-out from the Caravel master to N_MACROS user macros.
// Each macro owns a 16 MB window (adr[27:24]) inside the BASE_NIBBLE region.
// Only one transaction is in flight at a time. Every access is bounded by a timeout
// that answers with ERR_DATA. The response path (ack/data) is registered.
// Optional feature: define WB_MUX_TIMEOUT_IRQ_EN to get a sticky timeout interrupt.
module wb_macro_mux #(
    parameter int          N_MACROS       = 11,
    parameter logic [3:0]  BASE_NIBBLE    = 4'h3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [N_MACROS-1:0]      la_rst_i,
    output logic [N_MACROS-1:0]      m_rst_o,
    output logic [N_MACROS-1:0]      m_wbs_stb_o,
    input  logic [N_MACROS-1:0]      m_wbs_ack_i,
    input  logic [N_MACROS*32-1:0]   m_wbs_dat_i,
    output logic                     busy_o,
    output logic [7:0]               err_cnt_o,
    output logic                     irq_o,
    input  logic                     irq_clr_i
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [15:0]         TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [N_MACROS-1:0] SEL_LSB  = N_MACROS'(1);

    state_t      state;
    logic [3:0]  sel;
    logic [15:0] timer;
    logic        req;
    logic [3:0]  idx;
    logic        idx_ok;
    logic        mst_live;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        timeout_hit;
    logic [7:0]  err_next;

    assign req         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIBBLE);
    assign idx         = wbs_adr_i[27:24];
    assign idx_ok      = int'(idx) < N_MACROS;
    assign mst_live    = wbs_cyc_i & wbs_stb_i;
    assign timeout_hit = (state == WAIT) && mst_live && !sel_ack && (timer == TMO_LAST);
    assign err_next    = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;
    assign busy_o      = (state != IDLE);

    // Macro resets follow the LA bits and are forced while the SoC is in reset.
    assign m_rst_o = la_rst_i | {N_MACROS{~wb_rst_n_i}};

    // Pick ack and data of the selected macro only; every other macro is ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_MACROS; i++) begin
            if (sel == 4'(i)) begin
                sel_ack = m_wbs_ack_i[i];
                sel_dat = m_wbs_dat_i[32*i +: 32];
            end
        end
    end

    // Transaction FSM: decode in IDLE, strobe the macro in WAIT, one-cycle ack in RESP.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            sel         <= '0;
            timer       <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            m_wbs_stb_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (idx_ok) begin
                            sel         <= idx;
                            timer       <= '0;
                            m_wbs_stb_o <= SEL_LSB << idx;
                            state       <= WAIT;
                        end else begin
                            wbs_dat_o <= ERR_DATA;
                            err_cnt_o <= err_next;
                            wbs_ack_o <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!mst_live) begin
                        // Master gave up: drop the strobe quietly, no ack, no error.
                        m_wbs_stb_o <= '0;
                        state       <= IDLE;
                    end else if (sel_ack) begin
                        // Ack beats a timeout landing in the same cycle.
                        wbs_dat_o   <= sel_dat;
                        wbs_ack_o   <= 1'b1;
                        m_wbs_stb_o <= '0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        wbs_dat_o   <= ERR_DATA;
                        err_cnt_o   <= err_next;
                        wbs_ack_o   <= 1'b1;
                        m_wbs_stb_o <= '0;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_MUX_TIMEOUT_IRQ_EN
    // Sticky timeout interrupt; a new timeout wins over a simultaneous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            irq_o <= 1'b0;
        else if (timeout_hit)
            irq_o <= 1'b1;
        else if (irq_clr_i)
            irq_o <= 1'b0;
    end
`else
    assign irq_o = 1'b0;
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
`endif

    // Low address bits are decoded inside the macros themselves.
    logic unused_adr;
    assign unused_adr = &{1'b0, wbs_adr_i[23:0]};

endmodule

// File: tb/tb_wb_macro_mux.sv
// tb_wb_macro_mux: scoreboard bench for wb_macro_mux (N_MACROS=11, TIMEOUT_CYCLES=16).
// Expected read data is queued when a request is issued and popped when wbs_ack_o rises.
// Build with or without WB_MUX_TIMEOUT_IRQ_EN; interrupt expectations follow the macro.
module tb_wb_macro_mux;
    localparam int          N   = 11;
    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef WB_MUX_TIMEOUT_IRQ_EN
    localparam logic        IRQ_EN = 1'b1;
`else
    localparam logic        IRQ_EN = 1'b0;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n_i;
    logic              wbs_cyc_i, wbs_stb_i;
    logic [31:0]       wbs_adr_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [N-1:0]      la_rst_i, m_rst_o, m_wbs_stb_o, m_wbs_ack_i;
    logic [N*32-1:0]   m_wbs_dat_i;
    logic              busy_o, irq_o, irq_clr_i;
    logic [7:0]        err_cnt_o;

    logic [31:0]       mdat [N];
    int                dly  [N];
    int                cnt  [N];
    logic [N-1:0]      noise;
    logic [N-1:0]      av;
    logic [31:0]       exp_q [$];
    logic [31:0]       e;
    int                errs = 0;
    int                checks = 0;
    int                lat;

    wb_macro_mux #(.N_MACROS(N), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_rst_i(la_rst_i), .m_rst_o(m_rst_o),
        .m_wbs_stb_o(m_wbs_stb_o), .m_wbs_ack_i(m_wbs_ack_i), .m_wbs_dat_i(m_wbs_dat_i),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    for (genvar g = 0; g < N; g++) begin : g_dat
        assign m_wbs_dat_i[32*g +: 32] = mdat[g];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Macro model: ack dly[i] cycles after its strobe rises (dly<0 never acks), plus noise.
    always @(posedge wb_clk_i) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_wbs_stb_o[i]) begin
                av[i] = (dly[i] >= 0) && (cnt[i] == dly[i]);
                cnt[i]++;
            end else begin
                av[i] = 1'b0;
                cnt[i] = 0;
            end
        end
        m_wbs_ack_i = av | noise;
    end

    // Scoreboard: every ack must match the oldest expected response.
    always @(negedge wb_clk_i) begin
        if (wb_rst_n_i && wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", {31'd0, wbs_ack_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", wbs_dat_o, e);
            end
        end
    end

    // One master read; exp_lat<0 means "ack no later than cycle 2".
    task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp_dat,
                         input string tag, input int exp_lat);
        int  idx;
        bit  mapped;
        int  l;
        idx    = int'(adr[27:24]);
        mapped = (adr[31:28] == 4'h3) && (idx < N);
        exp_q.push_back(exp_dat);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = adr;
        l = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge wb_clk_i);
            if (n == 1 && mapped) chk({tag, "_stb"}, 32'(m_wbs_stb_o), 32'(1) << idx);
            if (wbs_ack_o) begin
                l = n;
                break;
            end
        end
        if (l < 0) exp_q.delete();
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        else              chk({tag, "_lat_le2"}, {31'd0, (l >= 0 && l <= 2)}, 32'd1);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},  {31'd0, wbs_ack_o}, 32'd0);
        chk({tag, "_dat"},  wbs_dat_o, 32'd0);
        chk({tag, "_stb"},  32'(m_wbs_stb_o), 32'd0);
        chk({tag, "_err"},  32'(err_cnt_o), 32'd0);
        chk({tag, "_irq"},  {31'd0, irq_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_mrst"}, 32'(m_rst_o), 32'h7FF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_n_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_adr_i = '0;
        la_rst_i = '0; irq_clr_i = 1'b0; noise = '0; m_wbs_ack_i = '0;
        for (int i = 0; i < N; i++) begin
            mdat[i] = 32'hA000_0000 | i;
            dly[i]  = -1;
            cnt[i]  = 0;
        end

        // Reset values and macro reset mapping.
        #3 chk_reset("rst");
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        chk("mrst_idle", 32'(m_rst_o), 32'd0);
        la_rst_i = 11'h008;
        #1 chk("mrst_la3", 32'(m_rst_o), 32'h008);
        la_rst_i = '0;

        // Macro 2 acks 4 cycles after its strobe.
        mdat[2] = 32'h1234_5678; dly[2] = 4;
        wb_rd(32'h3200_0000, 32'h1234_5678, "m2", 6);

        // Macro 5 ack noise must not leak into a macro 2 access.
        mdat[2] = 32'hCAFE_0002; mdat[5] = 32'h5555_5555; dly[2] = 2; noise[5] = 1'b1;
        wb_rd(32'h3200_0010, 32'hCAFE_0002, "m2_noise", 4);
        noise = '0;

        // Minimum latency and the highest mapped macro.
        dly[0] = 0;
        wb_rd(32'h3000_0000, 32'hA000_0000, "m0_min", 2);
        dly[10] = 1;
        wb_rd(32'h3A00_0000, 32'hA000_000A, "m10", 3);

        // Unmapped index returns the error word immediately.
        wb_rd(32'h3C00_0000, ERR, "unmapped", -1);
        chk("unmapped_errcnt", 32'(err_cnt_o), 32'd1);
        chk("unmapped_irq", {31'd0, irq_o}, 32'd0);

        // Other base nibble is not ours: no strobe, no ack.
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h2200_0000;
        lat = 0;
        repeat (5) begin
            @(negedge wb_clk_i);
            if (busy_o || m_wbs_stb_o != '0 || wbs_ack_o) lat++;
        end
        chk("foreign_ignored", 32'(lat), 32'd0);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

        // Timeout: 16 WAIT cycles, then error word.
        wb_rd(32'h3700_0000, ERR, "tmo", TO + 1);
        chk("tmo_errcnt", 32'(err_cnt_o), 32'd2);
        chk("tmo_irq", {31'd0, irq_o}, {31'd0, IRQ_EN});
        repeat (3) @(negedge wb_clk_i);
        chk("tmo_irq_hold", {31'd0, irq_o}, {31'd0, IRQ_EN});
        @(posedge wb_clk_i); #1 irq_clr_i = 1'b1;
        @(posedge wb_clk_i); #1 irq_clr_i = 1'b0;
        @(negedge wb_clk_i);
        chk("tmo_irq_clr", {31'd0, irq_o}, 32'd0);

        // Timeout and clear in the same cycle: set wins.
        exp_q.push_back(ERR);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3700_0000;
        for (int n = 0; n <= TO; n++) @(negedge wb_clk_i);
        irq_clr_i = 1'b1;
        @(negedge wb_clk_i);
        chk("sc_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk("sc_irq_set_wins", {31'd0, irq_o}, {31'd0, IRQ_EN});
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; irq_clr_i = 1'b0;
        @(negedge wb_clk_i);
        chk("sc_irq_cleared", {31'd0, irq_o}, 32'd0);
        chk("sc_errcnt", 32'(err_cnt_o), 32'd3);

        // Master abort in WAIT, then a late ack that must be ignored.
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3400_0000;
        repeat (4) @(negedge wb_clk_i);
        chk("abort_stb_on", 32'(m_wbs_stb_o), 32'h010);
        @(posedge wb_clk_i); #1 wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        chk("abort_stb_off", 32'(m_wbs_stb_o), 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        noise[4] = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("late_ack_busy", {31'd0, busy_o}, 32'd0);
        noise = '0;
        chk("abort_errcnt", 32'(err_cnt_o), 32'd3);
        mdat[4] = 32'h4444_0004; dly[4] = 1;
        wb_rd(32'h3400_0000, 32'h4444_0004, "after_abort", 3);

        // Async reset in the middle of WAIT.
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3100_0000;
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_n_i = 1'b0;
        #1 chk_reset("midrst");
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1 wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        chk("midrst_after_busy", {31'd0, busy_o}, 32'd0);

        // 300 unmapped hits saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            wb_rd(32'h3B00_0000 + (32'(i % 5) << 24), ERR, "unm", -1);
            if (i == 253) chk("errcnt_254", 32'(err_cnt_o), 32'd254);
        end
        chk("errcnt_sat", 32'(err_cnt_o), 32'd255);
        chk("unm_irq", {31'd0, irq_o}, 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
